tt_rx_window_multi: RTL and testbench

Multi-flow receive-window checker for the time-triggered (TT) switch datapath. It sits between the TT receive port and the TT output buffer, and holds a flow table of `2**IDX_W` entries. Each entry holds a receive window, a destination port/buffer and an expected length. Every incoming TT frame is forwarded only if its flow is in the table and the global time at header arrival falls inside that flow's window; otherwise the frame is dropped and the drop reason is reported. This generalises the single-entry checker to many flows, wrap-around windows, length checking and drop statistics.

---
 rtl/tt_rx_window_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_tt_rx_window_multi.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_rx_window_multi.sv
// TT receive-window checker with a multi-entry flow table.
// Define TT_RXW_STATS_EN to add saturating drop-reason counters.
module tt_rx_window_multi #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int TIME_W = 64,
  parameter int IDX_W  = 2,
  parameter int PORT_W = 4,
  parameter int BUF_W  = 4,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_tt_data,
  input  logic [CTRL_W-1:0] in_tt_ctrl,
  input  logic              in_tt_wr,
  output logic              out_tt_rdy,
  output logic [DATA_W-1:0] out_buffer_data,
  output logic [CTRL_W-1:0] out_buffer_ctrl,
  output logic              out_buffer_wr,
  input  logic              in_buffer_rdy,
  output logic [PORT_W-1:0] out_switch_port,
  output logic [BUF_W-1:0]  out_switch_buffer,
  input  logic              in_table_wr,
  input  logic [IDX_W-1:0]  in_table_idx,
  input  logic              in_entry_valid,
  input  logic [15:0]       in_flow_id,
  input  logic [TIME_W-1:0] in_window_start,
  input  logic [TIME_W-1:0] in_window_end,
  input  logic [PORT_W-1:0] in_port_number,
  input  logic [BUF_W-1:0]  in_buffer_number,
  input  logic [LEN_W-1:0]  in_tt_length,
  output logic              out_table_rdy,
  input  logic [TIME_W-1:0] in_global_time,
  output logic              out_tt_flag_clear,
  output logic              out_drop_pulse,
  output logic [1:0]        out_drop_reason,
  output logic              out_len_err
`ifdef TT_RXW_STATS_EN
  ,
  output logic [31:0]       out_cnt_early,
  output logic [31:0]       out_cnt_late,
  output logic [31:0]       out_cnt_nomatch
`endif
);

  localparam int N = 2**IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]      ent_valid;
  logic [15:0]       ent_flow  [N];
  logic [TIME_W-1:0] ent_start [N];
  logic [TIME_W-1:0] ent_end   [N];
  logic [PORT_W-1:0] ent_port  [N];
  logic [BUF_W-1:0]  ent_buf   [N];
  logic [LEN_W-1:0]  ent_len   [N];

  logic [LEN_W-1:0]  len_q, cnt_q, cnt_d, cnt_inc;
  logic              accept, last;
  logic [15:0]       hdr_flow;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [TIME_W-1:0] w_start, w_end;
  logic              in_win, early;
  logic              fwd_d, latch_d, clr_d, lerr_d, drop_d;
  logic [1:0]        reason_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else if (in_table_wr) begin
      ent_valid[in_table_idx] <= in_entry_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_table_wr) begin
      ent_flow[in_table_idx]  <= in_flow_id;
      ent_start[in_table_idx] <= in_window_start;
      ent_end[in_table_idx]   <= in_window_end;
      ent_port[in_table_idx]  <= in_port_number;
      ent_buf[in_table_idx]   <= in_buffer_number;
      ent_len[in_table_idx]   <= in_tt_length;
    end
  end

  assign out_table_rdy = 1'b1;
  assign out_tt_rdy = rst ? in_buffer_rdy :
                      (state_q == S_DROP) ? 1'b1 :
                      in_buffer_rdy;
  assign accept   = in_tt_wr & out_tt_rdy;
  assign last     = |in_tt_ctrl;
  assign hdr_flow = in_tt_data[DATA_W-1 -: 16];

  // Descending scan so the lowest matching index is left in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (ent_valid[i] && ent_flow[i] == hdr_flow) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_start = ent_start[hit_idx];
  assign w_end   = ent_end[hit_idx];

  // A reversed window spans the time rollover; a miss there is late.
  always_comb begin
    if (w_start <= w_end) begin
      in_win = (in_global_time >= w_start) &&
               (in_global_time <= w_end);
      early  = in_global_time < w_start;
    end else begin
      in_win = (in_global_time >= w_start) ||
               (in_global_time <= w_end);
      early  = 1'b0;
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !last) begin
          state_d = (hit && in_win) ? S_FWD : S_DROP;
        end
      end
      S_FWD: begin
        if (accept && last) state_d = S_IDLE;
      end
      S_DROP: begin
        if (accept && last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fwd_d    = 1'b0;
    latch_d  = 1'b0;
    clr_d    = 1'b0;
    lerr_d   = 1'b0;
    drop_d   = 1'b0;
    reason_d = 2'd0;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hit && in_win) begin
            fwd_d   = 1'b1;
            latch_d = 1'b1;
            cnt_d   = LEN_W'(1);
            if (last) begin
              clr_d  = 1'b1;
              lerr_d = (ent_len[hit_idx] != '0) &&
                       (ent_len[hit_idx] != LEN_W'(1));
            end
          end else begin
            drop_d   = 1'b1;
            reason_d = !hit ? 2'd3 :
                       early ? 2'd1 : 2'd2;
          end
        end
      end
      S_FWD: begin
        if (accept) begin
          fwd_d = 1'b1;
          cnt_d = cnt_inc;
          if (last) begin
            clr_d  = 1'b1;
            lerr_d = (len_q != '0) && (len_q != cnt_inc);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_buffer_wr     <= 1'b0;
      out_buffer_data   <= '0;
      out_buffer_ctrl   <= '0;
      out_switch_port   <= '0;
      out_switch_buffer <= '0;
      out_tt_flag_clear <= 1'b0;
      out_len_err       <= 1'b0;
      out_drop_pulse    <= 1'b0;
      out_drop_reason   <= 2'd0;
      len_q             <= '0;
      cnt_q             <= '0;
    end else begin
      out_buffer_wr     <= fwd_d;
      out_tt_flag_clear <= clr_d;
      out_len_err       <= lerr_d;
      out_drop_pulse    <= drop_d;
      out_drop_reason   <= reason_d;
      cnt_q             <= cnt_d;
      if (fwd_d) begin
        out_buffer_data <= in_tt_data;
        out_buffer_ctrl <= in_tt_ctrl;
      end
      if (latch_d) begin
        out_switch_port   <= ent_port[hit_idx];
        out_switch_buffer <= ent_buf[hit_idx];
        len_q             <= ent_len[hit_idx];
      end
    end
  end

`ifdef TT_RXW_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_early   <= '0;
      out_cnt_late    <= '0;
      out_cnt_nomatch <= '0;
    end else if (drop_d) begin
      if (reason_d == 2'd1 && !(&out_cnt_early))
        out_cnt_early <= out_cnt_early + 32'd1;
      if (reason_d == 2'd2 && !(&out_cnt_late))
        out_cnt_late <= out_cnt_late + 32'd1;
      if (reason_d == 2'd3 && !(&out_cnt_nomatch))
        out_cnt_nomatch <= out_cnt_nomatch + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_rx_window_multi.sv
// Scoreboard bench for tt_rx_window_multi.
// Driver queues hand-computed expectations; monitor pops on outputs.
module tb_tt_rx_window_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_tt_data;
  logic [7:0]  in_tt_ctrl;
  logic        in_tt_wr;
  logic        out_tt_rdy;
  logic [63:0] out_buffer_data;
  logic [7:0]  out_buffer_ctrl;
  logic        out_buffer_wr;
  logic        in_buffer_rdy;
  logic [3:0]  out_switch_port;
  logic [3:0]  out_switch_buffer;
  logic        in_table_wr;
  logic [1:0]  in_table_idx;
  logic        in_entry_valid;
  logic [15:0] in_flow_id;
  logic [63:0] in_window_start;
  logic [63:0] in_window_end;
  logic [3:0]  in_port_number;
  logic [3:0]  in_buffer_number;
  logic [15:0] in_tt_length;
  logic        out_table_rdy;
  logic [63:0] in_global_time;
  logic        out_tt_flag_clear;
  logic        out_drop_pulse;
  logic [1:0]  out_drop_reason;
  logic        out_len_err;
`ifdef TT_RXW_STATS_EN
  logic [31:0] out_cnt_early;
  logic [31:0] out_cnt_late;
  logic [31:0] out_cnt_nomatch;
`endif

  tt_rx_window_multi dut (
    .clk               (clk),
    .rst               (rst),
    .in_tt_data        (in_tt_data),
    .in_tt_ctrl        (in_tt_ctrl),
    .in_tt_wr          (in_tt_wr),
    .out_tt_rdy        (out_tt_rdy),
    .out_buffer_data   (out_buffer_data),
    .out_buffer_ctrl   (out_buffer_ctrl),
    .out_buffer_wr     (out_buffer_wr),
    .in_buffer_rdy     (in_buffer_rdy),
    .out_switch_port   (out_switch_port),
    .out_switch_buffer (out_switch_buffer),
    .in_table_wr       (in_table_wr),
    .in_table_idx      (in_table_idx),
    .in_entry_valid    (in_entry_valid),
    .in_flow_id        (in_flow_id),
    .in_window_start   (in_window_start),
    .in_window_end     (in_window_end),
    .in_port_number    (in_port_number),
    .in_buffer_number  (in_buffer_number),
    .in_tt_length      (in_tt_length),
    .out_table_rdy     (out_table_rdy),
    .in_global_time    (in_global_time),
    .out_tt_flag_clear (out_tt_flag_clear),
    .out_drop_pulse    (out_drop_pulse),
    .out_drop_reason   (out_drop_reason),
    .out_len_err       (out_len_err)
`ifdef TT_RXW_STATS_EN
    ,
    .out_cnt_early     (out_cnt_early),
    .out_cnt_late      (out_cnt_late),
    .out_cnt_nomatch   (out_cnt_nomatch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] d;
    logic [7:0]  c;
    logic [3:0]  p;
    logic [3:0]  b;
    logic        clr;
    logic        lerr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic push_fwd(input logic [63:0] d,
                          input logic [7:0] c,
                          input logic [3:0] p,
                          input logic [3:0] b,
                          input logic clr,
                          input logic lerr);
    exp_t e;
    e.kind = 0; e.d = d; e.c = c;
    e.p = p; e.b = b; e.clr = clr; e.lerr = lerr;
    q.push_back(e);
  endtask

  task automatic push_drop(input int reason);
    exp_t e;
    e.kind = reason; e.d = '0; e.c = '0;
    e.p = '0; e.b = '0; e.clr = 1'b0; e.lerr = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: every output event must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (out_buffer_wr) begin
      chk("wr_expected",
          64'(q.size() != 0 && q[0].kind == 0), 64'd1);
      if (q.size() != 0 && q[0].kind == 0) begin
        e = q.pop_front();
        chk("data", out_buffer_data, e.d);
        chk("ctrl", 64'(out_buffer_ctrl), 64'(e.c));
        chk("port", 64'(out_switch_port), 64'(e.p));
        chk("buf", 64'(out_switch_buffer), 64'(e.b));
        chk("flag_clear", 64'(out_tt_flag_clear), 64'(e.clr));
        chk("len_err", 64'(out_len_err), 64'(e.lerr));
      end
    end else if (out_tt_flag_clear || out_len_err) begin
      chk("stray_pulse", 64'(out_tt_flag_clear | out_len_err), 64'd0);
    end
    if (out_drop_pulse) begin
      chk("drop_expected",
          64'(q.size() != 0 && q[0].kind != 0), 64'd1);
      if (q.size() != 0 && q[0].kind != 0) begin
        e = q.pop_front();
        chk("drop_reason", 64'(out_drop_reason), 64'(e.kind));
      end
    end
  end

  task automatic send_word(input logic [63:0] d,
                           input logic [7:0] c,
                           input logic [63:0] t,
                           input logic stall);
    int n;
    in_tt_data = d;
    in_tt_ctrl = c;
    in_global_time = t;
    in_tt_wr = 1'b1;
    if (stall) begin
      in_buffer_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 in_buffer_rdy = 1'b1;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (out_tt_rdy) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1 in_tt_wr = 1'b0;
  endtask

  task automatic wr_entry(input logic [1:0] idx,
                          input logic v,
                          input logic [15:0] flow,
                          input logic [63:0] ws,
                          input logic [63:0] we,
                          input logic [3:0] p,
                          input logic [3:0] b,
                          input logic [15:0] len);
    in_table_idx = idx; in_entry_valid = v;
    in_flow_id = flow; in_window_start = ws;
    in_window_end = we; in_port_number = p;
    in_buffer_number = b; in_tt_length = len;
    in_table_wr = 1'b1;
    @(posedge clk);
    #1 in_table_wr = 1'b0;
  endtask

  function automatic logic [63:0] word(input logic [15:0] flow,
                                       input int i);
    return {flow, 8'(i), 40'hAB_CDEF_0123};
  endfunction

  // kind 0 = forwarded, 1..3 = expected drop reason.
  task automatic frame(input logic [15:0] flow,
                       input int n,
                       input logic [63:0] t,
                       input int kind,
                       input logic [3:0] p,
                       input logic [3:0] b,
                       input logic lerr,
                       input int stall_at);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      logic [7:0]  c;
      d = word(flow, i);
      c = (i == n-1) ? 8'h01 : 8'h00;
      if (kind == 0)
        push_fwd(d, c, p, b, i == n-1, (i == n-1) && lerr);
      else if (i == 0)
        push_drop(kind);
      send_word(d, c, t, i == stall_at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_tt_data = '0; in_tt_ctrl = '0; in_tt_wr = 1'b0;
    in_buffer_rdy = 1'b1; in_table_wr = 1'b0;
    in_table_idx = '0; in_entry_valid = 1'b0;
    in_flow_id = '0; in_window_start = '0;
    in_window_end = '0; in_port_number = '0;
    in_buffer_number = '0; in_tt_length = '0;
    in_global_time = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", 64'(out_buffer_wr), 64'd0);
    chk("rst_drop", 64'(out_drop_pulse), 64'd0);
    chk("rst_clr", 64'(out_tt_flag_clear), 64'd0);
    chk("rst_lerr", 64'(out_len_err), 64'd0);
    chk("rst_data", out_buffer_data, 64'd0);
    chk("rst_table_rdy", 64'(out_table_rdy), 64'd1);
    chk("rst_tt_rdy_hi", 64'(out_tt_rdy), 64'd1);
    in_buffer_rdy = 1'b0;
    #1 chk("rst_tt_rdy_lo", 64'(out_tt_rdy), 64'd0);
    in_buffer_rdy = 1'b1;
    rst = 1'b0;

    wr_entry(2'd0, 1'b1, 16'h1234, 64'h10, 64'h50, 4'd3, 4'd2, 16'd4);
    wr_entry(2'd3, 1'b1, 16'h1234, 64'h0, 64'hFFFF, 4'd9, 4'd7, 16'd0);
    wr_entry(2'd2, 1'b1, 16'h2222, 64'hFFFF_FFFF_FFFF_FFF0,
             64'h10, 4'd5, 4'd1, 16'd0);

    frame(16'h1234, 4, 64'h20, 0, 4'd3, 4'd2, 1'b0, -1);
    frame(16'h1234, 2, 64'h05, 1, 4'd0, 4'd0, 1'b0, -1);
    frame(16'h1234, 3, 64'h51, 2, 4'd0, 4'd0, 1'b0, -1);
    frame(16'h1234, 1, 64'h10, 0, 4'd3, 4'd2, 1'b1, -1);
    frame(16'h1234, 4, 64'h50, 0, 4'd3, 4'd2, 1'b0, -1);
    frame(16'h1234, 6, 64'h30, 0, 4'd3, 4'd2, 1'b1, 2);
    frame(16'h2222, 2, 64'h8, 0, 4'd5, 4'd1, 1'b0, -1);
    frame(16'h2222, 2, 64'hFFFF_FFFF_FFFF_FFF8,
          0, 4'd5, 4'd1, 1'b0, -1);
    frame(16'h2222, 2, 64'h20, 2, 4'd0, 4'd0, 1'b0, -1);

    push_drop(3);
    send_word(word(16'h9999, 0), 8'h00, 64'h20, 1'b0);
    in_buffer_rdy = 1'b0;
    @(negedge clk);
    chk("drop_rdy", 64'(out_tt_rdy), 64'd1);
    send_word(word(16'h9999, 1), 8'h00, 64'h20, 1'b0);
    send_word(word(16'h9999, 2), 8'h01, 64'h20, 1'b0);
    in_buffer_rdy = 1'b1;
`ifdef TT_RXW_STATS_EN
    chk("cnt_nomatch", 64'(out_cnt_nomatch), 64'd1);
    chk("cnt_early", 64'(out_cnt_early), 64'd1);
    chk("cnt_late", 64'(out_cnt_late), 64'd2);
`endif

    in_table_idx = 2'd1; in_entry_valid = 1'b1;
    in_flow_id = 16'h7777; in_window_start = 64'h0;
    in_window_end = 64'hFF; in_port_number = 4'd6;
    in_buffer_number = 4'd4; in_tt_length = 16'd0;
    in_table_wr = 1'b1;
    push_drop(3);
    send_word(word(16'h7777, 0), 8'h01, 64'h5, 1'b0);
    in_table_wr = 1'b0;
    frame(16'h7777, 1, 64'h5, 0, 4'd6, 4'd4, 1'b0, -1);

    push_fwd(word(16'h1234, 0), 8'h00, 4'd3, 4'd2, 1'b0, 1'b0);
    send_word(word(16'h1234, 0), 8'h00, 64'h20, 1'b0);
    push_fwd(word(16'h1234, 1), 8'h00, 4'd3, 4'd2, 1'b0, 1'b0);
    send_word(word(16'h1234, 1), 8'h00, 64'h20, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_wr", 64'(out_buffer_wr), 64'd0);
    chk("mid_rst_port", 64'(out_switch_port), 64'd0);
    chk("mid_rst_drop", 64'(out_drop_pulse), 64'd0);
    rst = 1'b0;
    frame(16'h1234, 2, 64'h20, 3, 4'd0, 4'd0, 1'b0, -1);
`ifdef TT_RXW_STATS_EN
    chk("cnt_nomatch_rst", 64'(out_cnt_nomatch), 64'd1);
`endif

    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
